instr_fetch: RTL and testbench

- Fetch stage directly downstream of the core control block.
- Consumes jump/jump_addr/flush/stall_n, drives the instruction bus with a pipelined req/gnt/rvalid handshake, and buffers returned words in a small FIFO.
- Presents {pc, instr} to decode.
- Discards stale in-flight responses after redirects so decode never sees wrong-path instructions.

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: pipelined fetch stage with req/gnt/rvalid bus, redirect squashing and a small fetch buffer
module instr_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    input  logic        flush,
    input  logic        stall_n,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        if_misalign
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 2);

    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_n;

    logic [31:0]   fetch_pc, deliver_pc, hold_addr, jump_tgt, push_pc, push_instr, last_pc, last_instr;
    logic [OW-1:0] outstanding, outstanding_n, discard_cnt;
    logic [AW-1:0] rd_ptr, wr_ptr, wr_idx;
    logic [CW-1:0] count;
    logic          stale_req, req_hold, redirect, mis_jump, gnt, keep, push, pop, issue;
    logic [31:0]   mem_pc    [FIFO_DEPTH];
    logic [31:0]   mem_instr [FIFO_DEPTH];

`ifdef IF_MISALIGN_CHK_EN
    logic mem_mis [FIFO_DEPTH];
    logic last_mis;
    assign mis_jump    = jump && jump_addr[1:0] != 2'b00;
    assign if_misalign = count != '0 ? mem_mis[rd_ptr] : last_mis;
    always_ff @(posedge clk or posedge rst_sync)
        if (rst_sync) last_mis <= 1'b0;
        else last_mis <= if_misalign;
    always_ff @(posedge clk)
        if (push) mem_mis[wr_idx] <= mis_jump;
`else
    logic unused_jump_lsb;
    assign mis_jump        = 1'b0;
    assign unused_jump_lsb = ^jump_addr[1:0];
`endif

    assign redirect      = jump || flush;
    assign jump_tgt      = {jump_addr[31:2], 2'b00};
    assign gnt           = ibus_req && ibus_gnt;
    assign keep          = ibus_rvalid && discard_cnt == '0 && !redirect;
    assign push          = keep || mis_jump;
    assign push_pc       = mis_jump ? jump_addr : deliver_pc;
    assign push_instr    = mis_jump ? 32'h0000_0013 : ibus_rdata;
    assign if_valid      = count != '0 && !flush;
    assign pop           = if_valid && stall_n;
    assign wr_idx        = redirect ? '0 : wr_ptr;
    assign outstanding_n = outstanding + OW'(gnt) - OW'(ibus_rvalid);
    assign if_pc         = count != '0 ? mem_pc[rd_ptr] : last_pc;
    assign if_instr      = count != '0 ? mem_instr[rd_ptr] : last_instr;
    // A pending request is re-presented unchanged until granted, even after a redirect.
    assign ibus_req      = !rst_sync && (req_hold || issue);
    assign ibus_addr     = req_hold ? hold_addr : fetch_pc;

    // The head leaving this cycle frees its slot, which keeps a zero-wait bus at one word per cycle.
    always_comb begin
        state_n = jump ? (mis_jump ? HALT : RUN) : (flush ? HALT : state);
        issue   = state == RUN
               && 32'(outstanding - discard_cnt) + 32'(count) - 32'(pop) < 32'(FIFO_DEPTH)
               && 32'(outstanding) < 32'(MAX_OUTSTANDING);
    end

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            deliver_pc  <= RESET_PC;
            hold_addr   <= '0;
            req_hold    <= 1'b0;
            stale_req   <= 1'b0;
            outstanding <= '0;
            discard_cnt <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            last_pc     <= '0;
            last_instr  <= '0;
        end else begin
            state       <= state_n;
            req_hold    <= ibus_req && !ibus_gnt;
            hold_addr   <= ibus_addr;
            stale_req   <= redirect ? ibus_req && !ibus_gnt : stale_req && !gnt;
            outstanding <= outstanding_n;
            discard_cnt <= redirect ? outstanding_n
                         : discard_cnt - OW'(ibus_rvalid && discard_cnt != '0) + OW'(gnt && stale_req);
            fetch_pc    <= jump ? jump_tgt : fetch_pc + (gnt && !stale_req ? 32'd4 : 32'd0);
            deliver_pc  <= jump ? jump_tgt : deliver_pc + (keep ? 32'd4 : 32'd0);
            rd_ptr      <= redirect ? '0 : rd_ptr + AW'(pop);
            wr_ptr      <= wr_idx + AW'(push);
            count       <= (redirect ? '0 : count - CW'(pop)) + CW'(push);
            last_pc     <= if_pc;
            last_instr  <= if_instr;
        end
    end

    always_ff @(posedge clk)
        if (push) begin
            mem_pc[wr_idx]    <= push_pc;
            mem_instr[wr_idx] <= push_instr;
        end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with an in-order bus model returning addr as data
`timescale 1ns/1ps
module tb_instr_fetch;
    logic        clk = 1'b0, rst_sync = 1'b1, jump = 1'b0, flush = 1'b0, stall_n = 1'b1;
    logic [31:0] jump_addr = '0;
    logic        ibus_req, ibus_gnt, ibus_rvalid, if_valid;
    logic [31:0] ibus_addr, ibus_rdata, if_instr, if_pc;
`ifdef IF_MISALIGN_CHK_EN
    logic        if_misalign;
`endif
    logic        gnt_en = 1'b1;
    int          lat = 1;
    logic        rv [8];
    logic [31:0] rd [8];
    int          n_chk = 0, n_fail = 0;

    instr_fetch dut (
        .clk(clk), .rst_sync(rst_sync), .jump(jump), .jump_addr(jump_addr), .flush(flush),
        .stall_n(stall_n), .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
        .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc)
`ifdef IF_MISALIGN_CHK_EN
        , .if_misalign(if_misalign)
`endif
    );

    always #5 clk = ~clk;

    assign ibus_gnt    = ibus_req && gnt_en;
    assign ibus_rvalid = rv[0];
    assign ibus_rdata  = rd[0];

    // Fixed-latency response pipe: a grant in cycle C answers in cycle C+lat.
    always @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            for (int i = 0; i < 8; i++) begin
                rv[i] <= 1'b0;
                rd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                rv[i] <= rv[i+1];
                rd[i] <= rd[i+1];
            end
            rv[7] <= 1'b0;
            if (ibus_req && ibus_gnt) begin
                rv[lat-1] <= 1'b1;
                rd[lat-1] <= ibus_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int l, input logic g);
        rst_sync = 1'b1;
        jump = 1'b0;
        flush = 1'b0;
        stall_n = 1'b1;
        lat = l;
        gnt_en = g;
        tick();
        tick();
        rst_sync = 1'b0;
        #1;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_req", ibus_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 0);

        rst_sync = 1'b0;
        #1;
        for (int c = 0; c < 7; c++) begin
            chk("t1_req", ibus_req, 1);
            chk("t1_addr", ibus_addr, 32'(4 * c));
            if (c >= 2) begin
                chk("t1_valid", if_valid, 1);
                chk("t1_pc", if_pc, 32'(4 * (c - 2)));
                chk("t1_instr", if_instr, 32'(4 * (c - 2)));
            end else chk("t1_empty", if_valid, 0);
            if (c < 6) tick();
        end

        stall_n = 1'b0;
        for (int c = 7; c <= 10; c++) begin
            tick();
            chk("t2_req_off", ibus_req, 0);
            chk("t2_hold_valid", if_valid, 1);
            chk("t2_hold_pc", if_pc, 32'd16);
        end
        tick();
        stall_n = 1'b1;
        #1;
        chk("t2_req_on", ibus_req, 1);
        chk("t2_addr", ibus_addr, 32'd24);
        for (int k = 0; k < 4; k++) begin
            chk("t2_valid", if_valid, 1);
            chk("t2_pc", if_pc, 32'(16 + 4 * k));
            chk("t2_instr", if_instr, 32'(16 + 4 * k));
            tick();
        end

        do_reset(3, 1'b1);
        chk("t3_addr0", ibus_addr, 0);
        tick();
        chk("t3_addr1", ibus_addr, 4);
        tick();
        chk("t3_credit", ibus_req, 0);
        jump = 1'b1;
        jump_addr = 32'h100;
        tick();
        jump = 1'b0;
        chk("t3_noreq", ibus_req, 0);
        chk("t3_drop", if_valid, 0);
        tick();
        chk("t3_req", ibus_req, 1);
        chk("t3_addr", ibus_addr, 32'h100);
        repeat (3) begin
            tick();
            chk("t3_drop", if_valid, 0);
        end
        tick();
        chk("t3_valid", if_valid, 1);
        chk("t3_pc", if_pc, 32'h100);
        chk("t3_instr", if_instr, 32'h100);
        tick();
        chk("t3_pc2", if_pc, 32'h104);
        chk("t3_instr2", if_instr, 32'h104);

        do_reset(1, 1'b0);
        chk("t4_req", ibus_req, 1);
        chk("t4_addr", ibus_addr, 0);
        tick();
        jump = 1'b1;
        jump_addr = 32'h200;
        tick();
        jump = 1'b0;
        chk("t4_held_req", ibus_req, 1);
        chk("t4_held_addr", ibus_addr, 0);
        tick();
        chk("t4_held_req2", ibus_req, 1);
        chk("t4_held_addr2", ibus_addr, 0);
        gnt_en = 1'b1;
        tick();
        chk("t4_new_req", ibus_req, 1);
        chk("t4_new_addr", ibus_addr, 32'h200);
        tick();
        chk("t4_drop", if_valid, 0);
        tick();
        chk("t4_valid", if_valid, 1);
        chk("t4_pc", if_pc, 32'h200);
        chk("t4_instr", if_instr, 32'h200);

        do_reset(1, 1'b1);
        repeat (4) tick();
        chk("t5_pre_pc", if_pc, 32'd8);
        flush = 1'b1;
        #1;
        chk("t5_flush_valid", if_valid, 0);
        tick();
        flush = 1'b0;
        chk("t5_halt_req", ibus_req, 0);
        chk("t5_empty", if_valid, 0);
        tick();
        chk("t5_halt_req2", ibus_req, 0);
        jump = 1'b1;
        jump_addr = 32'h40;
        tick();
        jump = 1'b0;
        chk("t5_req", ibus_req, 1);
        chk("t5_addr", ibus_addr, 32'h40);
        tick();
        tick();
        chk("t5_valid", if_valid, 1);
        chk("t5_pc", if_pc, 32'h40);
        chk("t5_instr", if_instr, 32'h40);
        tick();
        chk("t5_pc2", if_pc, 32'h44);

        do_reset(1, 1'b1);
        jump = 1'b1;
        jump_addr = 32'h102;
        tick();
        jump = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        chk("t6_noreq", ibus_req, 0);
        chk("t6_valid", if_valid, 1);
        chk("t6_pc", if_pc, 32'h102);
        chk("t6_instr", if_instr, 32'h13);
        chk("t6_mis", if_misalign, 1);
`else
        chk("t6_req", ibus_req, 1);
        chk("t6_addr", ibus_addr, 32'h100);
        tick();
        tick();
        chk("t6_valid", if_valid, 1);
        chk("t6_pc", if_pc, 32'h100);
        chk("t6_instr", if_instr, 32'h100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
